// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver with 8x oversampling and majority voting.
//
// The RX line is synchronised, a 1->0 edge starts a frame, and each bit is
// decided by a 3-sample majority vote around mid-bit.  The received byte is
// presented through a valid/ack handshake.  Framing and overrun errors are
// flagged.
//
// Optional feature macro: UART_RX_PARITY_EN
//   When defined, the frame is 8E1.  A parity bit is received between DATA
//   and STOP, and the PAR_ERR output is added.
//
// Ports:
//   SCLK     in   system clock (posedge)
//   SCLR     in   asynchronous active-low reset
//   MODE     in   [1:0] baud select for the internal baud_gen
//   RX       in   serial line, idles high, asynchronous to SCLK
//   RX_ACK   in   consumer strobe, clears RX_VALID and OVR_ERR
//   RX_DATA  out  [7:0] last received byte (LSB received first)
//   RX_VALID out  unacknowledged byte present
//   FRM_ERR  out  1-cycle pulse, stop bit sampled 0
//   OVR_ERR  out  sticky, byte completed while RX_VALID was still set
//   PAR_ERR  out  (UART_RX_PARITY_EN only) 1-cycle pulse, bad even parity
//
// baud_gen -- 8x-oversample tick generator.  BAUD_CLK is a 1-SCLK pulse
// every 16/12/8/4 clocks for MODE 0/1/2/3.  It is used as an enable only.
// ---------------------------------------------------------------------------

module baud_gen (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] MODE,
    output logic       BAUD_CLK
);
    logic [3:0] cnt;
    logic [3:0] lim;

    always_comb begin
        lim = 4'd3;
        case (MODE)
            2'd0: lim = 4'd15;
            2'd1: lim = 4'd11;
            2'd2: lim = 4'd7;
            2'd3: lim = 4'd3;
            default: lim = 4'd3;
        endcase
    end

    // ">=" makes a MODE change that leaves cnt above the new limit wrap
    // immediately rather than run the full 4-bit range.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            cnt <= '0;
        else if (cnt >= lim)
            cnt <= '0;
        else
            cnt <= cnt + 4'd1;
    end

    assign BAUD_CLK = (cnt == lim);
endmodule

module uart_rx #(
    parameter int OVERSAMPLE  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       SCLK,
    input  logic       SCLR,
    input  logic [1:0] MODE,
    input  logic       RX,
    input  logic       RX_ACK,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       FRM_ERR,
`ifdef UART_RX_PARITY_EN
    output logic       PAR_ERR,
`endif
    output logic       OVR_ERR
);
    localparam int TCW = $clog2(OVERSAMPLE);
    localparam logic [TCW-1:0] TC_A    = TCW'(OVERSAMPLE/2 - 1);
    localparam logic [TCW-1:0] TC_B    = TCW'(OVERSAMPLE/2);
    localparam logic [TCW-1:0] TC_C    = TCW'(OVERSAMPLE/2 + 1);
    localparam logic [TCW-1:0] TC_LAST = TCW'(OVERSAMPLE - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PAR   = 3'd3;
`endif
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_BRK   = 3'd5;

    logic                   tick;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev;
    logic [2:0]             state;
    logic [TCW-1:0]         tc;
    logic [2:0]             idx;
    logic [7:0]             shreg;
    logic                   s_a;
    logic                   s_b;
    logic                   vote;
    logic                   decide;
    logic                   bit_end;
    logic                   done;
`ifdef UART_RX_PARITY_EN
    logic                   par_bit;
`endif

    baud_gen u_baud (
        .CLK      (SCLK),
        .RST      (~SCLR),
        .MODE     (MODE),
        .BAUD_CLK (tick)
    );

    always_ff @(posedge SCLK or negedge SCLR) begin
        if (!SCLR) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], RX};
            rx_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_s    = sync_q[SYNC_STAGES-1];
    // Third vote sample is the live synchronised value at the decision tick.
    assign vote    = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
    assign decide  = tick && (tc == TC_C);
    assign bit_end = tick && (tc == TC_LAST);

    always_ff @(posedge SCLK or negedge SCLR) begin
        if (!SCLR) begin
            state   <= S_IDLE;
            tc      <= '0;
            idx     <= '0;
            shreg   <= '0;
            s_a     <= 1'b1;
            s_b     <= 1'b1;
            done    <= 1'b0;
            FRM_ERR <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            FRM_ERR <= 1'b0;
            if (state != S_IDLE && tick) begin
                tc <= (tc == TC_LAST) ? '0 : tc + 1'b1;
                if (tc == TC_A) s_a <= rx_s;
                if (tc == TC_B) s_b <= rx_s;
            end
            case (state)
                S_IDLE: begin
                    tc  <= '0;
                    idx <= '0;
                    if (rx_prev && !rx_s) state <= S_START;
                end
                S_START: begin
                    if (decide && vote)
                        state <= S_IDLE;
                    else if (bit_end)
                        state <= S_DATA;
                end
                S_DATA: begin
                    if (decide) shreg[idx] <= vote;
                    if (bit_end) begin
                        if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PAR;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PAR: begin
                    if (decide)  par_bit <= vote;
                    if (bit_end) state   <= S_STOP;
                end
`endif
                S_STOP: begin
                    if (decide) begin
                        if (vote) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            FRM_ERR <= 1'b1;
                            state   <= S_BRK;
                        end
                    end
                end
                S_BRK: begin
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output handshake.  A load with a simultaneous ack keeps RX_VALID set and
    // clears OVR_ERR; a load without ack over a pending byte is an overrun.
    always_ff @(posedge SCLK or negedge SCLR) begin
        if (!SCLR) begin
            RX_DATA  <= '0;
            RX_VALID <= 1'b0;
            OVR_ERR  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            PAR_ERR  <= 1'b0;
`endif
        end else begin
`ifdef UART_RX_PARITY_EN
            PAR_ERR <= 1'b0;
`endif
            if (done) begin
                RX_DATA  <= shreg;
                RX_VALID <= 1'b1;
                OVR_ERR  <= RX_VALID & ~RX_ACK;
`ifdef UART_RX_PARITY_EN
                PAR_ERR  <= ^{shreg, par_bit};
`endif
            end else if (RX_ACK && RX_VALID) begin
                RX_VALID <= 1'b0;
                OVR_ERR  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed self-checking bench for uart_rx.
// Drives whole serial frames bit by bit and checks the handshake outputs at
// negedges against hand-computed values.
// ---------------------------------------------------------------------------

module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'd3;
    logic       rx = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frm_err;
    logic       ovr_err;
`ifdef UART_RX_PARITY_EN
    logic       par_err;
    int         par_cnt = 0;
`endif

    int checks = 0;
    int errors = 0;
    int bit_t  = 32;
    int frm_cnt  = 0;
    int flag_cnt = 0;

    uart_rx #(.OVERSAMPLE(8), .SYNC_STAGES(2)) dut (
        .SCLK     (clk),
        .SCLR     (rst_n),
        .MODE     (mode),
        .RX       (rx),
        .RX_ACK   (rx_ack),
        .RX_DATA  (rx_data),
        .RX_VALID (rx_valid),
        .FRM_ERR  (frm_err),
`ifdef UART_RX_PARITY_EN
        .PAR_ERR  (par_err),
`endif
        .OVR_ERR  (ovr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frm_err) frm_cnt <= frm_cnt + 1;
    always @(negedge clk) if (rx_valid | frm_err | ovr_err) flag_cnt <= flag_cnt + 1;
`ifdef UART_RX_PARITY_EN
    always @(posedge clk) if (par_err) par_cnt <= par_cnt + 1;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_mode(input logic [1:0] m);
        mode = m;
        case (m)
            2'd0: bit_t = 8 * 16;
            2'd1: bit_t = 8 * 12;
            2'd2: bit_t = 8 * 8;
            default: bit_t = 8 * 4;
        endcase
    endtask

    task automatic hold(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        hold(1'b0, bit_t);
        for (int i = 0; i < 8; i++) hold(d[i], bit_t);
`ifdef UART_RX_PARITY_EN
        hold(^d, bit_t);
`endif
        hold(stop, bit_t);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    initial begin
        int base;
        bit found;

        // 1. reset, then long idle line
        set_mode(2'd3);
        repeat (4) @(negedge clk);
        check("reset_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_data", {24'd0, rx_data}, 32'd0);
        rst_n = 1'b1;
        base = flag_cnt;
        repeat (20 * bit_t) @(negedge clk);
        check("idle_flags", flag_cnt - base, 0);

        // 2. 0xA5 at every MODE, then ack
        for (int m = 0; m < 4; m++) begin
            set_mode(m[1:0]);
            hold(1'b1, 2 * bit_t);
            base = frm_cnt;
            send_frame(8'hA5, 1'b1);
            check("a5_valid", {31'd0, rx_valid}, 32'd1);
            check("a5_data", {24'd0, rx_data}, 32'hA5);
            check("a5_frm", frm_cnt - base, 0);
            ack_pulse();
            check("a5_ack_clear", {31'd0, rx_valid}, 32'd0);
        end

        // 3. short glitch is rejected, then 0x3C
        set_mode(2'd3);
        hold(1'b0, bit_t / 4);
        hold(1'b1, 3 * bit_t);
        check("glitch_valid", {31'd0, rx_valid}, 32'd0);
        send_frame(8'h3C, 1'b1);
        check("3c_valid", {31'd0, rx_valid}, 32'd1);
        check("3c_data", {24'd0, rx_data}, 32'h3C);
        ack_pulse();

        // 4. framing error, held-low line, then 0x81
        base = frm_cnt;
        hold(1'b0, bit_t);
        for (int i = 0; i < 8; i++) hold(i[0] ? 1'b0 : 1'b1, bit_t);
`ifdef UART_RX_PARITY_EN
        hold(1'b0, bit_t);
`endif
        hold(1'b0, 30 * bit_t);
        check("frm_pulse_count", frm_cnt - base, 1);
        check("frm_valid", {31'd0, rx_valid}, 32'd0);
        hold(1'b1, 2 * bit_t);
        check("brk_valid", {31'd0, rx_valid}, 32'd0);
        send_frame(8'h81, 1'b1);
        check("81_data", {24'd0, rx_data}, 32'h81);
        check("81_valid", {31'd0, rx_valid}, 32'd1);
        check("81_frm", frm_cnt - base, 1);
        ack_pulse();

        // 5. overrun and ack on the load cycle
        send_frame(8'h11, 1'b1);
        check("11_ovr", {31'd0, ovr_err}, 32'd0);
        send_frame(8'h22, 1'b1);
        check("ovr_data", {24'd0, rx_data}, 32'h22);
        check("ovr_flag", {31'd0, ovr_err}, 32'd1);
        check("ovr_valid", {31'd0, rx_valid}, 32'd1);
        ack_pulse();
        check("ovr_ack_valid", {31'd0, rx_valid}, 32'd0);
        check("ovr_ack_flag", {31'd0, ovr_err}, 32'd0);
        send_frame(8'h44, 1'b1);
        send_frame(8'h66, 1'b1);
        check("ovr2_flag", {31'd0, ovr_err}, 32'd1);
        found = 1'b0;
        fork
            send_frame(8'h33, 1'b1);
            begin
                for (int i = 0; i < 4000 && !found; i++) begin
                    @(negedge clk);
                    if (dut.done) begin
                        rx_ack = 1'b1;
                        found = 1'b1;
                    end
                end
                @(negedge clk);
                rx_ack = 1'b0;
            end
        join
        check("load_ack_seen", {31'd0, found}, 32'd1);
        check("load_ack_data", {24'd0, rx_data}, 32'h33);
        check("load_ack_valid", {31'd0, rx_valid}, 32'd1);
        check("load_ack_ovr", {31'd0, ovr_err}, 32'd0);

        // 6. reset during bit 4 of 0xF0, then 0x0F
        hold(1'b1, 2 * bit_t);
        hold(1'b0, bit_t);
        for (int i = 0; i < 4; i++) hold(1'b0, bit_t);
        hold(1'b1, bit_t / 2);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_valid", {31'd0, rx_valid}, 32'd0);
        check("midrst_data", {24'd0, rx_data}, 32'd0);
        check("midrst_ovr", {31'd0, ovr_err}, 32'd0);
        rst_n = 1'b1;
        hold(1'b1, 2 * bit_t);
        send_frame(8'h0F, 1'b1);
        check("0f_data", {24'd0, rx_data}, 32'h0F);
        check("0f_valid", {31'd0, rx_valid}, 32'd1);
        ack_pulse();

`ifdef UART_RX_PARITY_EN
        base = par_cnt;
        hold(1'b0, bit_t);
        for (int i = 0; i < 8; i++) hold(i < 3 ? 1'b1 : 1'b0, bit_t);
        hold(1'b0, bit_t);
        hold(1'b1, bit_t);
        repeat (2) @(negedge clk);
        check("par_err_pulse", par_cnt - base, 1);
        check("par_data", {24'd0, rx_data}, 32'h07);
        check("par_valid", {31'd0, rx_valid}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
